// File: rtl/eth_tx_sequencer.sv
// Ethernet TX sequencer: CPU-fed 32-bit word FIFO that streams frames big-endian, one byte per handshake.
// Optional build macro ETH_TX_MIN_PAD_EN: zero-pads frames shorter than 60 bytes.
`timescale 1ns/1ps
module eth_tx_sequencer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send_data_we,
    input  logic                  send_ena_we,
    input  logic [31:0]           wdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  tx_done,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  cmd_err
);
    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam int                  CW    = (LEN_W > DEPTH_LOG2 + 3) ? LEN_W : DEPTH_LOG2 + 3;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, PAD, DONE} state_t;

    state_t                state_q;
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [31:0]           shift_q;
    logic [1:0]            byte_idx_q;
    logic [LEN_W-1:0]      rem_q;
    logic                  overflow_q, overflow_d;
    logic                  cmd_err_q, cmd_err_d;
`ifdef ETH_TX_MIN_PAD_EN
    logic [5:0]            pad_rem_q;
`endif

    logic [LEN_W-1:0] len;
    logic             clr, pop, push_ok, launch_req, enough;
    logic [CW-1:0]    bytes_avail, len_ext;

    assign len         = wdata[LEN_W-1:0];
    assign clr         = wdata[31];
    assign launch_req  = send_ena_we && (len != '0);
    assign bytes_avail = CW'({count_q, 2'b00});
    assign len_ext     = CW'(len);
    assign enough      = bytes_avail >= len_ext;
    assign pop         = (state_q == LOAD);
    // A full FIFO still accepts a push when the LOAD pop frees a slot in the same cycle.
    assign push_ok     = send_data_we && ((count_q != FULL) || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Clear comes first so a same-cycle set event wins.
    always_comb begin
        overflow_d = overflow_q;
        cmd_err_d  = cmd_err_q;
        if (send_ena_we && clr) begin
            overflow_d = 1'b0;
            cmd_err_d  = 1'b0;
        end
        if (send_data_we && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (launch_req && ((state_q != IDLE) || !enough)) begin
            cmd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            rem_q      <= '0;
`ifdef ETH_TX_MIN_PAD_EN
            pad_rem_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_req && enough) begin
                        rem_q   <= len;
                        state_q <= LOAD;
`ifdef ETH_TX_MIN_PAD_EN
                        pad_rem_q <= (len < LEN_W'(60)) ? (6'd60 - len[5:0]) : 6'd0;
`endif
                    end
                end
                LOAD: begin
                    shift_q    <= mem_q[rd_ptr_q];
                    byte_idx_q <= 2'd0;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
`ifdef ETH_TX_MIN_PAD_EN
                            state_q <= (pad_rem_q != 6'd0) ? PAD : DONE;
`else
                            state_q <= DONE;
`endif
                        end else if (byte_idx_q == 2'd3) begin
                            state_q <= LOAD;
                        end else begin
                            shift_q    <= {shift_q[23:0], 8'h00};
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
`ifdef ETH_TX_MIN_PAD_EN
                PAD: begin
                    if (tx_ready) begin
                        pad_rem_q <= pad_rem_q - 1'b1;
                        if (pad_rem_q == 6'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_valid   = (state_q == SEND) || (state_q == PAD);
    assign tx_data    = (state_q == SEND) ? shift_q[31:24] : 8'h00;
`ifdef ETH_TX_MIN_PAD_EN
    assign tx_last    = ((state_q == SEND) && (rem_q == LEN_W'(1)) && (pad_rem_q == 6'd0))
                     || ((state_q == PAD) && (pad_rem_q == 6'd1));
`else
    assign tx_last    = (state_q == SEND) && (rem_q == LEN_W'(1));
`endif
    assign tx_done    = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Bench for eth_tx_sequencer: directed and randomized frames checked against a word-queue/byte-list model.
`timescale 1ns/1ps
module tb_eth_tx_sequencer;
    localparam int DEPTH_LOG2 = 4;
    localparam int LEN_W      = 11;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                rst;
    logic                send_data_we, send_ena_we, tx_ready;
    logic [31:0]         wdata;
    logic [7:0]          tx_data;
    logic                tx_valid, tx_last, tx_done, busy, overflow, cmd_err;
    logic [DEPTH_LOG2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelFifo[$];
    logic        modelOverflow = 1'b0;
    logic        modelCmdErr   = 1'b0;

    eth_tx_sequencer #(.DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .send_data_we(send_data_we), .send_ena_we(send_ena_we), .wdata(wdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .tx_done(tx_done), .busy(busy), .fifo_count(fifo_count),
        .overflow(overflow), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of CPU store activity; returns #1 after the edge with strobes released.
    task automatic applyStimulus(input logic dataWe, input logic enaWe, input logic [31:0] data);
        send_data_we = dataWe;
        send_ena_we  = enaWe;
        wdata        = data;
        @(posedge clk);
        #1;
        send_data_we = 1'b0;
        send_ena_we  = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] w);
        if (modelFifo.size() < DEPTH) modelFifo.push_back(w);
        else modelOverflow = 1'b1;
        applyStimulus(1'b1, 1'b0, w);
    endtask

    task automatic checkIdleStatus(input string tag);
        @(negedge clk);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_count"}, fifo_count, modelFifo.size());
        checkOutput({tag, "_overflow"}, overflow, modelOverflow);
        checkOutput({tag, "_cmdErr"}, cmd_err, modelCmdErr);
        @(posedge clk);
        #1;
    endtask

    // readyMode: 0 = always ready, 1 = toggle starting high, 2 = random.
    task automatic runFrame(input int len, input int readyMode, input bit disturb);
        logic [7:0]  expBytes[$];
        logic [31:0] w;
        logic [31:0] extraWord = $urandom;
        logic [7:0]  heldData = 8'h00;
        logic        heldLast = 1'b0;
        logic        expLast;
        int          nWords = (len + 3) / 4;
        int          idx = 0, cyc = 0, lastCyc = -10, disturbStep = 0;
        bit          held = 0, doneSeen = 0;

        for (int i = 0; i < nWords; i++) begin
            w = modelFifo.pop_front();
            for (int b = 3; b >= 0; b--) begin
                if (expBytes.size() < len) expBytes.push_back(w[8*b +: 8]);
            end
        end
`ifdef ETH_TX_MIN_PAD_EN
        while (expBytes.size() < 60) expBytes.push_back(8'h00);
`endif

        tx_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'(len));
        @(negedge clk);
        checkOutput("launchBusy", busy, 1);
        checkOutput("launchNoValid", tx_valid, 0);
        @(posedge clk);
        #1;

        while (!doneSeen && cyc < 3000) begin
            if (readyMode == 0) tx_ready = 1'b1;
            else if (readyMode == 1) tx_ready = (cyc % 2 == 0);
            else tx_ready = 1'($urandom_range(0, 1));
            send_ena_we  = 1'b0;
            send_data_we = 1'b0;
            if (disturb && disturbStep == 1) begin
                send_ena_we = 1'b1;
                wdata       = 32'd5;
                modelCmdErr = 1'b1;
                disturbStep = 2;
            end else if (disturb && disturbStep == 2) begin
                send_data_we = 1'b1;
                wdata        = extraWord;
                modelFifo.push_back(extraWord);
                disturbStep  = 3;
            end
            @(negedge clk);
            if (held) begin
                checkOutput("holdValid", tx_valid, 1);
                checkOutput("holdData", tx_data, heldData);
                checkOutput("holdLast", tx_last, heldLast);
                held = 0;
            end
            if (tx_done) begin
                doneSeen = 1;
                checkOutput("doneTiming", cyc, lastCyc + 1);
                checkOutput("byteCount", idx, expBytes.size());
            end else if (tx_valid && tx_ready) begin
                if (idx < expBytes.size()) begin
                    expLast = (idx == expBytes.size() - 1);
                    checkOutput($sformatf("byte%0d", idx), tx_data, expBytes[idx]);
                    checkOutput($sformatf("last%0d", idx), tx_last, expLast);
                    if (expLast) lastCyc = cyc;
                end else begin
                    checkOutput("extraByte", idx, expBytes.size() - 1);
                end
                idx++;
                if (disturb && idx == 10) disturbStep = 1;
            end else if (tx_valid) begin
                held     = 1;
                heldData = tx_data;
                heldLast = tx_last;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        send_ena_we  = 1'b0;
        send_data_we = 1'b0;
        tx_ready     = 1'b1;
        if (!doneSeen) checkOutput("frameTimeout", doneSeen, 1);
        @(negedge clk);
        checkOutput("donePulse", tx_done, 0);
        @(posedge clk);
        #1;
        checkIdleStatus("afterFrame");
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, len;
        rst = 1'b1;
        send_data_we = 1'b0;
        send_ena_we  = 1'b0;
        wdata        = '0;
        tx_ready     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstValid", tx_valid, 0);
        checkOutput("rstData", tx_data, 0);
        checkOutput("rstLast", tx_last, 0);
        checkOutput("rstDone", tx_done, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstCount", fifo_count, 0);
        checkOutput("rstOverflow", overflow, 0);
        checkOutput("rstCmdErr", cmd_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic 6-byte frame, ready high");
        pushWord(32'h1122_3344);
        pushWord(32'hAABB_CCDD);
        checkIdleStatus("twoPushed");
        runFrame(6, 0, 0);

        $display("[TB] same frame, ready toggling");
        pushWord(32'h1122_3344);
        pushWord(32'hAABB_CCDD);
        runFrame(6, 1, 0);

        $display("[TB] underfilled launch rejected, then cleared");
        pushWord($urandom);
        pushWord($urandom);
        applyStimulus(1'b0, 1'b1, 32'd9);
        modelCmdErr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rejectNoValid", tx_valid, 0);
            checkOutput("rejectIdle", busy, 0);
            checkOutput("rejectCmdErr", cmd_err, 1);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b1, 32'h8000_0000);
        modelCmdErr = 1'b0;
        checkIdleStatus("clearedErr");
        runFrame(8, 2, 0);

        $display("[TB] overflow, then 64-byte frame disturbed mid-flight");
        for (int i = 0; i < DEPTH + 1; i++) pushWord($urandom);
        checkIdleStatus("overflowed");
        runFrame(64, 0, 1);
        applyStimulus(1'b0, 1'b1, 32'h8000_0000);
        modelCmdErr   = 1'b0;
        modelOverflow = 1'b0;
        checkIdleStatus("flagsCleared");

        $display("[TB] short 4-byte frame");
        runFrame(4, 0, 0);

        $display("[TB] randomized frames");
        for (int iter = 0; iter < 6; iter++) begin
            n = $urandom_range(1, DEPTH - modelFifo.size());
            for (int i = 0; i < n; i++) pushWord($urandom);
            len = $urandom_range(1, 4 * modelFifo.size());
            runFrame(len, 2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_sequencer.md
Name: eth_tx_sequencer

Overview:
- Sequences the Ethernet NIC transmit path behind the memory-mapped store decode.
- The CPU stores payload words to the send-data address (0x830), which pushes them into an internal word FIFO.
- A store to the send-enable address (0x82c) with a byte length launches a frame.
- The block then streams the frame byte-wise to the MAC over a valid/ready handshake and reports busy/error status for CPU polling.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (default 16 words = 64 bytes).
- LEN_W, 11, width of the frame byte-length field (max 2047 bytes).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- send_data_we  input  1  write strobe for the send-data address; pushes wdata into the FIFO.
- send_ena_we  input  1  write strobe for the send-enable address; launch/clear command.
- wdata  input  32  CPU store data.
- tx_data  output  8  byte to MAC.
- tx_valid  output  1  tx_data valid.
- tx_last  output  1  final byte of the frame; qualified by tx_valid.
- tx_ready  input  1  MAC accepts the byte when tx_valid&&tx_ready.
- tx_done  output  1  one-cycle pulse after the last byte is accepted.
- busy  output  1  frame in progress (state != IDLE).
- fifo_count  output  DEPTH_LOG2+1  words currently buffered.
- overflow  output  1  sticky: push dropped because the FIFO was full.
- cmd_err  output  1  sticky: launch rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, sticky flags 0. Asserting rst mid-frame aborts immediately and discards FIFO contents; tx_valid drops asynchronously.
- Byte order: big-endian; wdata[31:24] is sent first.
- FIFO push (send_data_we): accepted in any state if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set. count updates as count + push − pop.
- Command (send_ena_we), with len=wdata[LEN_W-1:0] and clr=wdata[31]:
  - If clr=1, overflow and cmd_err clear this cycle. Any set event in the same cycle wins.
  - In IDLE, len==0 performs no launch.
  - In IDLE, len>0 and 4*count>=len latches the remaining count to len and goes to LOAD.
  - In IDLE, len>0 and 4*count<len sets cmd_err and stays IDLE.
  - In any non-IDLE state, a launch request (len>0) sets cmd_err and is ignored.
- States:
  - IDLE: waits for a valid launch as described above.
  - LOAD: pops one FIFO word into the shift register, sets byte_idx=0, goes to SEND. Lasts exactly 1 cycle.
  - SEND: tx_valid=1, tx_data=shift[31:24], tx_last=(remaining==1). On handshake, remaining decrements, then:
    - if remaining was 1, go to DONE;
    - else if byte_idx==3, go to LOAD;
    - else shift left by 8 and increment byte_idx.
    - While tx_ready=0, tx_data and tx_last hold stable.
  - DONE: tx_done=1 for one cycle, then IDLE. Unused trailing bytes of the last popped word are discarded.
- Latency:
  - Launch write in cycle N: busy=1 from N+1 (LOAD), first tx_valid at N+2.
  - Each word boundary inserts one LOAD bubble, so throughput is 4 bytes per 5 cycles with tx_ready held high.
- Words pushed during a frame remain queued for the next frame; they are never consumed by the current frame beyond ceil(len/4) words.

Optional Feature:
- ETH_TX_MIN_PAD_EN defined:
  - Frames with len<60 are padded after the payload with 0x00 bytes up to exactly 60 bytes. This adds a PAD state following the payload bytes.
  - tx_last is asserted on byte 60, and no extra FIFO words are popped.
  - The 4*count>=len check uses the original len.
- Not defined: exactly len bytes are sent with no padding.

Test Plan:
- Push 0x11223344 and 0xAABBCCDD, then launch len=6 with tx_ready=1 -> bytes 11 22 33 44 AA BB, tx_last on BB, tx_done one cycle later, fifo_count=0, busy=0.
- Same frame with tx_ready toggling 1/0 each cycle -> identical byte sequence, and tx_data is held stable during every ready=0 cycle.
- Launch len=9 with only 2 words buffered -> cmd_err=1, no tx_valid. Then launch with clr=1 and len=0 -> cmd_err=0.
- Push 17 words into an idle block with DEPTH_LOG2=4 -> fifo_count=16, overflow=1, and word 17 is absent from the next 64-byte frame.
- During a 64-byte frame, launch again and push one extra word -> cmd_err=1, the frame completes intact, and fifo_count ends at 1.
- With ETH_TX_MIN_PAD_EN defined, launch len=4 -> 4 payload bytes followed by 56 bytes of 0x00, tx_last on byte 60, exactly one word popped.
